// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
package seven_seg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  // Active-low segments: all ones means every segment is dark
  localparam logic [6:0] SEG_OFF = 7'b1111111;

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Load handshake between a display-value producer and the scan controller.
interface seven_seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load_valid;
  logic [4*NUM_DIGITS-1:0] load_value;
  logic                    load_ready;

  modport master (output load_valid, load_value, input  load_ready);
  modport slave  (input  load_valid, load_value, output load_ready);
endinterface

// File: rtl/seven_seg_scan_ctrl_dec.sv
// Hex nibble to active-low {a,b,c,d,e,f,g} segment pattern, segment a in the MSB.
module hex_to_seven_segment (
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = 7'b1111111;
    case (i_hex)
      4'h0: o_seg = 7'b0000001;
      4'h1: o_seg = 7'b1001111;
      4'h2: o_seg = 7'b0010010;
      4'h3: o_seg = 7'b0000110;
      4'h4: o_seg = 7'b1001100;
      4'h5: o_seg = 7'b0100100;
      4'h6: o_seg = 7'b0100000;
      4'h7: o_seg = 7'b0001111;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0000100;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b1100000;
      4'hC: o_seg = 7'b0110001;
      4'hD: o_seg = 7'b1000010;
      4'hE: o_seg = 7'b0110000;
      4'hF: o_seg = 7'b0111000;
      default: o_seg = 7'b1111111;
    endcase
  end
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with frame-synchronous value load.
// Optional leading-zero blanking: define SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  seven_seg_scan_ctrl_if.slave  ld,
  input  logic [NUM_DIGITS-1:0] digit_en,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [6:0]            seven_seg,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(SLOT_CYCLES);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  scan_state_e             r_state;
  logic [4*NUM_DIGITS-1:0] r_disp;
  logic [4*NUM_DIGITS-1:0] r_pend_val;
  logic                    r_pend;
  logic [NUM_DIGITS-1:0]   r_anode;
  logic [6:0]              r_seg;

  logic                    w_slot_end;
  logic                    w_frame_end;
  logic                    w_xfer;
  logic [3:0]              w_nib;
  logic [6:0]              w_seg;
  logic [NUM_DIGITS-1:0]   w_lz_keep;

  assign w_slot_end  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);
  assign w_xfer      = ld.load_valid && !r_pend;
  assign w_nib       = r_disp[{r_idx, 2'b00} +: 4];

  assign ld.load_ready = !r_pend;
  assign frame_done    = w_frame_end;
  assign anode         = r_anode;
  assign seven_seg     = r_seg;

  hex_to_seven_segment u_dec (
    .i_hex (w_nib),
    .o_seg (w_seg)
  );

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic w_seen;
  // Scan from the top nibble down; a digit is kept once any nibble at or above it is nonzero
  always_comb begin
    w_seen    = 1'b0;
    w_lz_keep = '0;
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      w_seen       = w_seen | (r_disp[4*d +: 4] != 4'h0);
      w_lz_keep[d] = w_seen | (d == 0);
    end
  end
`else
  assign w_lz_keep = '1;
`endif

  // Scan FSM; anode/segments register the current state and index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_state <= BLANK;
      r_anode <= '1;
      r_seg   <= SEG_OFF;
    end else begin
      if (w_slot_end) begin
        r_cnt   <= '0;
        r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        r_state <= BLANK;
      end else begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CNT_BLANK_LAST) r_state <= DRIVE;
      end

      if (r_state == DRIVE && digit_en[r_idx] && w_lz_keep[r_idx]) begin
        r_anode <= ~(NUM_DIGITS'(1) << r_idx);
        r_seg   <= w_seg;
      end else begin
        r_anode <= '1;
        r_seg   <= SEG_OFF;
      end
    end
  end

  // A pending value only reaches the display at frame end, so a frame is never torn
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_disp     <= '0;
      r_pend_val <= '0;
      r_pend     <= 1'b0;
    end else if (w_frame_end && r_pend) begin
      r_disp <= r_pend_val;
      r_pend <= 1'b0;
    end else if (w_xfer) begin
      r_pend_val <= ld.load_value;
      r_pend     <= 1'b1;
    end
  end

endmodule
